// File: rtl/avst_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module      : avst_pkt_rx
// Description : Avalon-ST packet sink with FWFT byte FIFO and per-packet
//               beat-count / byte-sum status record held until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module avst_pkt_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_end,
    output logic              rd_empty,
    output logic              pkt_valid,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [DATA_W-1:0] pkt_sum,
    output logic              pkt_err,
    input  logic              pkt_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IN_PKT = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              run_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [LEN_W-1:0]  len_acc_q, len_acc_d, pkt_len_q, pkt_len_d;
    logic [DATA_W-1:0] sum_acc_q, sum_acc_d, pkt_sum_q, pkt_sum_d;
    logic              err_acc_q, err_acc_d, pkt_err_q, pkt_err_d;

    logic              push, pop, full, len_sat;
    logic [DATA_W:0]   head;

    assign full      = (count_q == FULL_CNT);
    assign rd_empty  = (count_q == '0);
    assign pkt_valid = (state_q == S_HOLD);
    // Depends on registered state only, so sources may look at it combinationally.
    assign ready_in  = run_q & ~full & ~pkt_valid;
    assign push      = valid_in & ready_in;
    assign pop       = rd_en & ~rd_empty;
    assign head      = mem_q[rd_ptr_q];
    assign rd_data   = rd_empty ? '0 : head[DATA_W-1:0];
    assign rd_end    = rd_empty ? 1'b0 : head[DATA_W];
    assign pkt_len   = pkt_len_q;
    assign pkt_sum   = pkt_sum_q;
    assign pkt_err   = pkt_err_q;
    assign len_sat   = (len_acc_q == LEN_MAX);

    always_comb begin
        state_d   = state_q;
        len_acc_d = len_acc_q;
        sum_acc_d = sum_acc_q;
        err_acc_d = err_acc_q;
        pkt_len_d = pkt_len_q;
        pkt_sum_d = pkt_sum_q;
        pkt_err_d = pkt_err_q;
        count_d   = count_q;

        if (push) begin
            // Saturate the counter on overflow but keep summing and storing.
            len_acc_d = len_sat ? len_acc_q : len_acc_q + 1'b1;
            err_acc_d = err_acc_q | len_sat;
            sum_acc_d = sum_acc_q + data_in;
            state_d   = S_IN_PKT;
            if (end_in) begin
                pkt_len_d = len_acc_d;
                pkt_sum_d = sum_acc_d;
                pkt_err_d = err_acc_d;
                len_acc_d = '0;
                sum_acc_d = '0;
                err_acc_d = 1'b0;
                state_d   = S_HOLD;
            end
        end else if (pkt_valid && pkt_ack) begin
            state_d = S_IDLE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            len_acc_q <= '0;
            sum_acc_q <= '0;
            err_acc_q <= 1'b0;
            pkt_len_q <= '0;
            pkt_sum_q <= '0;
            pkt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            count_q   <= count_d;
            len_acc_q <= len_acc_d;
            sum_acc_q <= sum_acc_d;
            err_acc_q <= err_acc_d;
            pkt_len_q <= pkt_len_d;
            pkt_sum_q <= pkt_sum_d;
            pkt_err_q <= pkt_err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: contents are masked by rd_empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {end_in, data_in};
    end

endmodule
`default_nettype wire

// File: tb/tb_avst_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_avst_pkt_rx
// Description : Directed vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avst_pkt_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       end_in = 1'b0, valid_in = 1'b0, rd_en = 1'b0, pkt_ack = 1'b0;
    logic       rd_en2 = 1'b0, pkt_ack2 = 1'b0;

    logic       ready_in, rd_end, rd_empty, pkt_valid, pkt_err;
    logic [7:0] rd_data, pkt_len, pkt_sum;
    logic       ready2, rd_end2, rd_empty2, pkt_valid2, pkt_err2;
    logic [7:0] rd_data2, pkt_sum2;
    logic [1:0] pkt_len2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avst_pkt_rx #(.DATA_W(8), .DEPTH(16), .LEN_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .end_in(end_in),
        .valid_in(valid_in), .ready_in(ready_in), .rd_en(rd_en),
        .rd_data(rd_data), .rd_end(rd_end), .rd_empty(rd_empty),
        .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_sum(pkt_sum),
        .pkt_err(pkt_err), .pkt_ack(pkt_ack)
    );

    avst_pkt_rx #(.DATA_W(8), .DEPTH(16), .LEN_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .end_in(end_in),
        .valid_in(valid_in), .ready_in(ready2), .rd_en(rd_en2),
        .rd_data(rd_data2), .rd_end(rd_end2), .rd_empty(rd_empty2),
        .pkt_valid(pkt_valid2), .pkt_len(pkt_len2), .pkt_sum(pkt_sum2),
        .pkt_err(pkt_err2), .pkt_ack(pkt_ack2)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        eop;
        logic        rd;
        logic        ack;
        logic [28:0] exp;
    } vec_t;

    vec_t vecs [12];

    // {ready, pkt_valid, pkt_len, pkt_sum, pkt_err, rd_empty, rd_data, rd_end}
    function automatic logic [28:0] e(logic rdy, logic pv, logic [7:0] len,
                                      logic [7:0] sum, logic err, logic emp,
                                      logic [7:0] rdat, logic rend);
        return {rdy, pv, len, sum, err, emp, rdat, rend};
    endfunction

    function automatic vec_t v(logic valid, logic [7:0] data, logic eop,
                               logic rd, logic ack, logic [28:0] exp);
        vec_t r;
        r.valid = valid; r.data = data; r.eop = eop; r.rd = rd; r.ack = ack;
        r.exp = exp;
        return r;
    endfunction

    function automatic logic [28:0] got();
        return {ready_in, pkt_valid, pkt_len, pkt_sum, pkt_err, rd_empty, rd_data, rd_end};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0]  = v(0, 8'h00, 0, 0, 0, e(1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0));
        vecs[1]  = v(1, 8'h5A, 1, 0, 0, e(0, 1, 8'h01, 8'h5A, 0, 0, 8'h5A, 1));
        vecs[2]  = v(0, 8'h00, 0, 0, 0, e(0, 1, 8'h01, 8'h5A, 0, 0, 8'h5A, 1));
        vecs[3]  = v(1, 8'h77, 0, 0, 0, e(0, 1, 8'h01, 8'h5A, 0, 0, 8'h5A, 1));
        vecs[4]  = v(0, 8'h00, 0, 1, 1, e(1, 0, 8'h01, 8'h5A, 0, 1, 8'h00, 0));
        vecs[5]  = v(1, 8'h10, 0, 0, 0, e(1, 0, 8'h01, 8'h5A, 0, 0, 8'h10, 0));
        vecs[6]  = v(1, 8'h20, 0, 0, 0, e(1, 0, 8'h01, 8'h5A, 0, 0, 8'h10, 0));
        vecs[7]  = v(1, 8'hF0, 1, 0, 0, e(0, 1, 8'h03, 8'h20, 0, 0, 8'h10, 0));
        vecs[8]  = v(0, 8'h00, 0, 1, 0, e(0, 1, 8'h03, 8'h20, 0, 0, 8'h20, 0));
        vecs[9]  = v(0, 8'h00, 0, 1, 0, e(0, 1, 8'h03, 8'h20, 0, 0, 8'hF0, 1));
        vecs[10] = v(0, 8'h00, 0, 1, 1, e(1, 0, 8'h03, 8'h20, 0, 1, 8'h00, 0));
        vecs[11] = v(0, 8'h00, 0, 0, 1, e(1, 0, 8'h03, 8'h20, 0, 1, 8'h00, 0));

        // Reset state while reset_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(got()), 64'(e(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0)));
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            valid_in = vecs[i].valid;
            data_in  = vecs[i].data;
            end_in   = vecs[i].eop;
            rd_en    = vecs[i].rd;
            pkt_ack  = vecs[i].ack;
            step();
            check($sformatf("vec%0d", i), 64'(got()), 64'(vecs[i].exp));
        end
        valid_in = 0; end_in = 0; rd_en = 0; pkt_ack = 0;

        // Fill to DEPTH with no reads, then one pop frees a slot.
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'h30 + i);
            step();
        end
        valid_in = 1'b0;
        check("fill_ready_low", 64'(ready_in), 64'(0));
        check("fill_head", 64'(rd_data), 64'(8'h30));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("fill_ready_back", 64'(ready_in), 64'(1));
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain%0d", i), 64'({rd_empty, rd_data}), 64'({1'b0, 8'(8'h30 + i)}));
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        check("drain_empty", 64'(rd_empty), 64'(1));

        // Asynchronous reset in the middle of a packet.
        valid_in = 1'b1; data_in = 8'hAA; step();
        data_in = 8'hBB; step();
        valid_in = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 64'(got()), 64'(e(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0)));
        #2;
        reset_n = 1'b1;
        step();
        check("post_reset_ready", 64'(ready_in), 64'(1));
        valid_in = 1'b1; data_in = 8'h01; end_in = 1'b1;
        step();
        valid_in = 1'b0; end_in = 1'b0;
        check("post_reset_pkt", 64'(got()), 64'(e(0, 1, 8'h01, 8'h01, 0, 0, 8'h01, 1)));

        // Length overflow on the LEN_W=2 instance; main instance sees the same 5 beats.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(i);
            end_in   = (i == 5);
            step();
        end
        valid_in = 1'b0; end_in = 1'b0;
        check("ovf_status", 64'({pkt_valid2, pkt_len2, pkt_sum2, pkt_err2}),
              64'({1'b1, 2'd3, 8'h0F, 1'b1}));
        check("ovf_main_status", 64'({pkt_valid, pkt_len, pkt_sum, pkt_err}),
              64'({1'b1, 8'd5, 8'h0F, 1'b0}));
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("ovf_byte%0d", i), 64'({rd_empty2, rd_data2, rd_end2}),
                  64'({1'b0, 8'(i), (i == 5)}));
            rd_en2 = 1'b1;
            step();
            rd_en2 = 1'b0;
        end
        check("ovf_empty", 64'(rd_empty2), 64'(1));

        // Ack in HOLD while popping, with the source already presenting the next packet.
        pkt_ack = 1'b1; rd_en = 1'b1;
        valid_in = 1'b1; data_in = 8'h11; end_in = 1'b0;
        step();
        pkt_ack = 1'b0; rd_en = 1'b0;
        check("ack_release", 64'({ready_in, pkt_valid, rd_data}), 64'({1'b1, 1'b0, 8'h02}));
        step();
        data_in = 8'h22; end_in = 1'b1;
        step();
        valid_in = 1'b0; end_in = 1'b0;
        check("pkt2_status", 64'({ready_in, pkt_valid, pkt_len, pkt_sum, pkt_err}),
              64'({1'b0, 1'b1, 8'd2, 8'h33, 1'b0}));
        check("pkt2_head", 64'(rd_data), 64'(8'h02));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avst_pkt_rx.md
Name: avst_pkt_rx

Overview:
- Avalon-ST packet sink: the receive-side counterpart of the adder's byte/end stream.
- Accepts 8-bit beats with end-of-packet marking through a ready/valid handshake.
- Buffers the beats in a FIFO for a host read port.
- Produces a per-packet status record: beat count plus modulo-256 byte sum, held until the host acknowledges it.
- Placed after the adder's output stream, or after any block driving the same data/end/valid/ready interface.

Parameters:
- DATA_W, 8: beat width in bits.
- DEPTH, 16: FIFO entries; must be a power of 2, at least 2.
- LEN_W, 8: width of the packet beat counter.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- data_in, in, DATA_W: stream data.
- end_in, in, 1: marks the last beat of a packet.
- valid_in, in, 1: beat valid.
- ready_in, out, 1: sink can accept a beat this cycle.
- rd_en, in, 1: host pops the FIFO head.
- rd_data, out, DATA_W: FIFO head data.
- rd_end, out, 1: end flag of the FIFO head.
- rd_empty, out, 1: FIFO empty.
- pkt_valid, out, 1: status record pending.
- pkt_len, out, LEN_W: beat count of the completed packet.
- pkt_sum, out, DATA_W: sum of the packet's data bytes, mod 2^DATA_W.
- pkt_err, out, 1: packet exceeded 2^LEN_W-1 beats.
- pkt_ack, in, 1: host consumes the status record.

Behaviour:
- Reset (reset_n=0, takes effect immediately, asynchronously):
  - ready_in=0, rd_empty=1, rd_data=0, rd_end=0.
  - pkt_valid=0, pkt_len=0, pkt_sum=0, pkt_err=0.
  - FIFO pointers and counters cleared; FSM returns to IDLE.
  - Any partial packet is discarded.
- Handshake: a beat is accepted on the rising edge where valid_in=1 and ready_in=1.
- ready_in = reset released AND FIFO not full AND pkt_valid=0. It is registered-state only and never depends on valid_in or end_in.
- After reset release, ready_in first goes to 1 at the first rising edge; it may combine the registered reset state.
- FSM states:
  - IDLE: no beats yet for the current packet.
    - Accepted beat with end_in=0 -> IN_PKT.
    - Accepted beat with end_in=1 -> HOLD (single-beat packet).
  - IN_PKT: accumulating.
    - Accepted beat with end_in=1 -> HOLD.
  - HOLD: pkt_valid=1 and ready_in=0.
    - pkt_ack=1 -> IDLE on the next edge. pkt_valid falls and ready_in may rise in the same cycle.
- Accumulators:
  - On each accepted beat: len_acc += 1 and sum_acc += data_in (wraps mod 2^DATA_W).
  - When len_acc is at 2^LEN_W-1 and another beat arrives:
    - len_acc holds its value.
    - An error flag sets.
    - The data is still stored.
- On an accepted end beat:
  - pkt_len, pkt_sum and pkt_err load the final values, including that beat.
  - pkt_valid goes to 1 on the same edge.
  - The accumulators clear.
- Status outputs stay stable while pkt_valid=1.
- pkt_ack while pkt_valid=0 is ignored.
- FIFO (first-word fall-through):
  - rd_data and rd_end show the head whenever rd_empty=0.
  - rd_en while empty is ignored; there is no underflow.
  - A simultaneous push and pop when full: no push occurs, since ready_in=0; the pop proceeds.
  - A simultaneous push and pop when non-empty: the occupancy count is unchanged.
  - A push into an empty FIFO: rd_empty falls on the next edge. Latency from acceptance to visibility is 1 cycle.
  - Pointers wrap modulo DEPTH.
- Status versus data:
  - The status record may be acked before the host has drained that packet's bytes.
  - The FIFO keeps the packet order; rd_end delimits packets.

Test Plan:
- Reset, then single-beat packet data_in=0x5A, end_in=1:
  - pkt_valid=1 one edge later, with pkt_len=1, pkt_sum=0x5A, pkt_err=0.
  - ready_in=0 until pkt_ack.
  - rd_data=0x5A, rd_end=1.
- Packet 0x10, 0x20, 0xF0 (end on last):
  - pkt_len=3, pkt_sum=0x20 (wrapped).
  - Three pops return those bytes in order; rd_end=1 only on 0xF0.
- Fill with 16 non-end beats while holding rd_en=0:
  - ready_in=0 after the 16th acceptance.
  - One rd_en restores ready_in=1 on the next cycle.
  - No beat is lost or duplicated.
- Assert reset_n=0 mid-packet after 2 beats:
  - All outputs go to reset values immediately.
  - The next packet (0x01, end) reports pkt_len=1, pkt_sum=0x01.
- LEN_W=2, 5-beat packet:
  - pkt_len=3, pkt_err=1.
  - All 5 bytes are in the FIFO.
- Assert pkt_ack in the HOLD cycle while rd_en pops the same packet, with back-to-back source beats:
  - The second packet is accepted starting the cycle after ack.
  - Its status is correct and independent of the first.
